// File: rtl/fcmp_pkg.sv
// Shared definitions for the float-compare scheduler: op codes, slot states
// and IEEE-754 single-precision field positions.
package fcmp_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_EQ = 2'd0;
  localparam op_t OP_NE = 2'd1;
  localparam op_t OP_LT = 2'd2;
  localparam op_t OP_LE = 2'd3;

  localparam logic [7:0] EXP_MAX = 8'hFF;
  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MANT_MSB = 22;

  typedef enum logic {
    SLOT_IDLE = 1'b0,
    SLOT_BUSY = 1'b1
  } slot_state_t;

endpackage

// File: rtl/fcmp_core.sv
// Combinational IEEE-754 single-precision compare: (a, b, op) -> z.
// NaN operands make every op false except NE; +0 and -0 compare equal.
module fcmp_core
  import fcmp_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  op_t         op,
  output logic        z
);

  logic [30:0] mag_a, mag_b;
  logic        a_nan, b_nan, both_zero, eq, lt;

  always_comb begin
    mag_a     = a[EXP_MSB:0];
    mag_b     = b[EXP_MSB:0];
    a_nan     = (a[EXP_MSB:EXP_LSB] == EXP_MAX) && (a[MANT_MSB:0] != '0);
    b_nan     = (b[EXP_MSB:EXP_LSB] == EXP_MAX) && (b[MANT_MSB:0] != '0);
    both_zero = (mag_a == '0) && (mag_b == '0);
    eq        = (a == b) || both_zero;

    // Sign-magnitude ordering; negative magnitudes sort in reverse.
    if (both_zero)                   lt = 1'b0;
    else if (a[SIGN_BIT] != b[SIGN_BIT]) lt = a[SIGN_BIT];
    else if (a[SIGN_BIT])            lt = (mag_a > mag_b);
    else                             lt = (mag_a < mag_b);

    if (a_nan || b_nan) begin
      z = (op == OP_NE);
    end else begin
      case (op)
        OP_EQ:   z = eq;
        OP_NE:   z = !eq;
        OP_LT:   z = lt;
        default: z = lt || eq;
      endcase
    end
  end

endmodule

// File: rtl/fcmp_sched.sv
// Round-robin scheduler sharing one pipelined float compare among N requesters.
// Handshake: a transfer occurs on a rising edge where req_valid[i] & req_ready[i].
module fcmp_sched
  import fcmp_pkg::*;
#(
  parameter int N       = 4,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  input  logic [32*N-1:0] req_a,
  input  logic [32*N-1:0] req_b,
  input  logic [2*N-1:0]  req_op,
  output logic [N-1:0]    rsp_valid,
  output logic [N-1:0]    rsp_z
);

  localparam int TW = $clog2(N);

  slot_state_t slot_q [N];
  slot_state_t slot_d [N];
  logic [N-1:0]  slot_idle, eligible, grant;
  logic [TW-1:0] rr_ptr, grant_idx;
  logic          found, transfer;

  // Slot FSM: state register
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n) slot_q[i] <= SLOT_IDLE;
      else        slot_q[i] <= slot_d[i];
    end
  end

  // Slot FSM: next state; the response cycle is the last BUSY cycle.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      slot_d[i] = slot_q[i];
      if (rsp_valid[i])  slot_d[i] = SLOT_IDLE;
      else if (grant[i]) slot_d[i] = SLOT_BUSY;
    end
  end

  // Slot FSM: outputs
  always_comb begin
    for (int i = 0; i < N; i++) slot_idle[i] = (slot_q[i] == SLOT_IDLE);
  end

  assign eligible = req_valid & slot_idle;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (int'(rr_ptr) + k) % N;
      if (!found && eligible[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = TW'(idx);
      end
    end
  end

  assign req_ready = rst_n ? grant : '0;
  assign transfer  = found;

  always_ff @(posedge clk) begin
    if (!rst_n)        rr_ptr <= '0;
    else if (transfer) rr_ptr <= (grant_idx == TW'(N - 1)) ? '0 : grant_idx + 1'b1;
  end

  logic          s1_v;
  logic [TW-1:0] s1_tag;
  logic [31:0]   s1_a, s1_b;
  op_t           s1_op;
  logic          core_z;

  always_ff @(posedge clk) begin
    if (!rst_n) s1_v <= 1'b0;
    else        s1_v <= transfer;
  end

  always_ff @(posedge clk) begin
    if (transfer) begin
      s1_tag <= grant_idx;
      s1_a   <= req_a[32*grant_idx +: 32];
      s1_b   <= req_b[32*grant_idx +: 32];
      s1_op  <= req_op[2*grant_idx +: 2];
    end
  end

  fcmp_core u_core (
    .a  (s1_a),
    .b  (s1_b),
    .op (s1_op),
    .z  (core_z)
  );

  logic          fin_v, fin_z;
  logic [TW-1:0] fin_tag;

  if (LATENCY == 1) begin : g_direct
    assign fin_v   = s1_v;
    assign fin_z   = core_z;
    assign fin_tag = s1_tag;
  end else begin : g_pipe
    localparam int D = LATENCY - 1;
    logic [D-1:0]  dv, dz;
    logic [TW-1:0] dtag [D];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        dv <= '0;
      end else begin
        dv[0] <= s1_v;
        for (int i = 1; i < D; i++) dv[i] <= dv[i-1];
      end
    end

    always_ff @(posedge clk) begin
      dz[0]   <= core_z;
      dtag[0] <= s1_tag;
      for (int i = 1; i < D; i++) begin
        dz[i]   <= dz[i-1];
        dtag[i] <= dtag[i-1];
      end
    end

    assign fin_v   = dv[D-1];
    assign fin_z   = dz[D-1];
    assign fin_tag = dtag[D-1];
  end

  always_comb begin
    rsp_valid = '0;
    rsp_z     = '0;
    if (fin_v) begin
      rsp_valid[fin_tag] = 1'b1;
      rsp_z[fin_tag]     = fin_z;
    end
  end

endmodule

// File: tb/tb_fcmp_sched.sv
// Directed bench for fcmp_sched: expected responses are queued at each
// handshake and checked by a monitor when rsp_valid pulses.
module tb_fcmp_sched;
  import fcmp_pkg::*;

  localparam int N       = 4;
  localparam int LATENCY = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_z;
  logic [32*N-1:0] req_a, req_b;
  logic [2*N-1:0]  req_op;

  fcmp_sched #(.N(N), .LATENCY(LATENCY)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_z     (rsp_z)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  // scoreboard
  int         n_vec  = 0;
  int         n_fail = 0;
  logic [4:0] exp_q[$];
  int         due_q[$];
  logic       exp_z_of [N];

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic [4:0] e;
    int         d;
    if (rsp_valid !== '0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        d = due_q.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'(e[4:1]));
        chk("rsp_z", 32'(|(rsp_z & e[4:1])), 32'(e[0]));
        chk("rsp_latency", cyc, d);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (rst_n && req_valid[i] && req_ready[i]) begin
        exp_q.push_back({4'(1 << i), exp_z_of[i]});
        due_q.push_back(cyc + LATENCY);
      end
    end
  end

  // driver tasks
  task automatic set_req(int r, logic [1:0] op, logic [31:0] a, logic [31:0] b, logic z);
    req_a[r*32 +: 32] = a;
    req_b[r*32 +: 32] = b;
    req_op[r*2 +: 2]  = op;
    exp_z_of[r]       = z;
    req_valid[r]      = 1'b1;
  endtask

  task automatic issue(int r, logic [1:0] op, logic [31:0] a, logic [31:0] b, logic z);
    int ok;
    int waited;
    ok = 0;
    waited = 0;
    @(posedge clk); #1;
    set_req(r, op, a, b, z);
    while (ok == 0 && waited <= 20) begin
      @(negedge clk);
      if (req_ready[r]) ok = 1;
      else waited++;
    end
    chk("issue_accept", 32'(ok), 32'd1);
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
    repeat (LATENCY + 1) @(posedge clk);
  endtask

  task automatic set_all_fair();
    set_req(0, OP_EQ, 32'h3F800000, 32'h3F800000, 1'b1);
    set_req(1, OP_LT, 32'h40000000, 32'h3F800000, 1'b0);
    set_req(2, OP_LE, 32'hFF800000, 32'h00000000, 1'b1);
    set_req(3, OP_NE, 32'h3F800000, 32'h3F800001, 1'b1);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        z;
  } vec_t;
  vec_t vecs[$];

  initial begin
    rst_n     = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    for (int i = 0; i < N; i++) exp_z_of[i] = 1'b0;

    // reset state: ready held low even with every request valid
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_z", 32'(rsp_z), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    req_valid = '0;
    repeat (2) @(posedge clk);

    // single request from requester 1
    @(posedge clk); #1;
    set_req(1, OP_EQ, 32'h3F800000, 32'h3F800000, 1'b1);
    @(negedge clk);
    chk("single_ready", 32'(req_ready), 32'b0010);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    chk("single_no_early_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("single_rsp_vec", 32'(rsp_valid), 32'b0010);
    chk("single_rsp_z", 32'(rsp_z[1]), 32'd1);
    repeat (2) @(posedge clk);

    // semantics sweep through requester 3
    vecs.push_back('{OP_NE, 32'h7FC00000, 32'h7FC00000, 1'b1});
    vecs.push_back('{OP_EQ, 32'h80000000, 32'h00000000, 1'b1});
    vecs.push_back('{OP_LT, 32'h80000000, 32'h00000000, 1'b0});
    vecs.push_back('{OP_LT, 32'hBF800000, 32'h3F800000, 1'b1});
    vecs.push_back('{OP_LE, 32'h7F800000, 32'h7F800000, 1'b1});
    vecs.push_back('{OP_LT, 32'hC0000000, 32'hBF800000, 1'b1});
    vecs.push_back('{OP_LT, 32'h00000001, 32'h00000002, 1'b1});
    vecs.push_back('{OP_LE, 32'h7FC00000, 32'h3F800000, 1'b0});
    vecs.push_back('{OP_EQ, 32'h7F800001, 32'h7F800001, 1'b0});
    vecs.push_back('{OP_EQ, 32'h7F800000, 32'hFF800000, 1'b0});
    vecs.push_back('{OP_LE, 32'hBF800000, 32'hBF800000, 1'b1});
    vecs.push_back('{OP_LT, 32'h3F800000, 32'hBF800000, 1'b0});
    vecs.push_back('{OP_LT, 32'hFF800000, 32'h80000000, 1'b1});
    vecs.push_back('{OP_LT, 32'h00000002, 32'h00000001, 1'b0});
    foreach (vecs[k]) issue(3, vecs[k].op, vecs[k].a, vecs[k].b, vecs[k].z);

    // fairness: all four held valid from rr_ptr = 0
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_all_fair();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("fair_grant", 32'(req_ready), 32'(1 << (k % 4)));
      @(posedge clk); #1;
    end
    req_valid = '0;
    repeat (LATENCY + 3) @(posedge clk);

    // busy blocking on requester 2 while requester 0 is still served
    #1;
    set_req(2, OP_LT, 32'h00000001, 32'h00000000, 1'b0);
    @(negedge clk);
    chk("busy_first_grant", 32'(req_ready), 32'b0100);
    @(posedge clk); #1;
    set_req(0, OP_EQ, 32'h80000000, 32'h00000000, 1'b1);
    @(negedge clk);
    chk("busy_other_granted", 32'(req_ready), 32'b0001);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("busy_blocked_in_rsp", 32'(req_ready), 32'd0);
    chk("busy_rsp_seen", 32'(rsp_valid), 32'b0100);
    @(posedge clk); #1;
    @(negedge clk);
    chk("busy_regrant", 32'(req_ready), 32'b0100);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    repeat (LATENCY + 3) @(posedge clk);

    // reset mid-flight discards outstanding work
    #1;
    set_req(0, OP_EQ, 32'h3F800000, 32'h3F800000, 1'b1);
    set_req(1, OP_LT, 32'h40000000, 32'h3F800000, 1'b0);
    @(negedge clk);
    chk("midrst_grant0", 32'(req_ready), 32'b0001);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ready_low", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    req_valid = '0;
    exp_q.delete();
    due_q.delete();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk); #1;
    set_all_fair();
    @(negedge clk);
    chk("midrst_first_grant", 32'(req_ready), 32'b0001);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("midrst_next_grant", 32'(req_ready), 32'b0010);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (LATENCY + 3) @(posedge clk);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
